// File: rtl/revive_fetch_align.sv
// revive_fetch_align: halfword-granular prefetch buffer and aligner in front of
// the RVC decompressor. It takes 32-bit fetch words and presents a 32-bit window
// (cir) that can start on any halfword. Decode returns 0, 1 or 2 consumed
// halfwords per cycle.
// Optional feature macro: REVIVE_FETCH_BYPASS_EN. When defined, an empty buffer
// forwards the incoming word straight to cir in the push cycle.
// Handshake: a word transfers on a rising edge where fetch_wvalid=1 and
// fetch_wready=1 and jump_now=0. fetch_wready comes only from the registered
// level and never from cir_use or fetch_wvalid. In a jump cycle the bus treats
// the presented word as stale.
module revive_fetch_align #(
    parameter  int DEPTH_HW = 6,
    localparam int W_LEVEL  = $clog2(DEPTH_HW + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        fetch_wdata,
    input  logic               fetch_wvalid,
    output logic               fetch_wready,
    input  logic               jump_now,
    input  logic               jump_target_hw,
    output logic [31:0]        cir,
    output logic [1:0]         cir_vld,
    output logic               cir_instr_vld,
    input  logic [1:0]         cir_use,
    output logic [W_LEVEL-1:0] buf_level
);
    localparam int PW = $clog2(DEPTH_HW);
    localparam logic [PW:0] DEPTH_P = (PW + 1)'(DEPTH_HW);

    logic [15:0]        buf_q [DEPTH_HW];
    logic [W_LEVEL-1:0] level_q, level_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic               drop_lo_q, drop_lo_d;

    logic               push;
    logic [15:0]        in_hw0, in_hw1;
    logic [1:0]         in_cnt;
    logic [1:0]         skip_cnt;
    logic [1:0]         wr_cnt;
    logic [1:0]         pop_cnt;
    logic [15:0]        st_lo, st_hi;
    logic [1:0]         st_vld;
    logic               we0, we1;
    logic [PW-1:0]      idx0, idx1;
    logic [15:0]        wd0, wd1;

    // Circular pointer increment by 0..2 with no gap at the wrap point.
    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [1:0] n);
        logic [PW:0] s;
        s = {1'b0, p} + {{(PW - 1){1'b0}}, n};
        if (s >= DEPTH_P) s = s - DEPTH_P;
        return s[PW-1:0];
    endfunction

    assign fetch_wready = (level_q <= W_LEVEL'(DEPTH_HW - 2));
    assign push         = fetch_wvalid & fetch_wready & ~jump_now;
    assign buf_level    = level_q;

    // Incoming halfwords after the optional drop of the low half on a mid-word jump target.
    always_comb begin
        in_hw0 = drop_lo_q ? fetch_wdata[31:16] : fetch_wdata[15:0];
        in_hw1 = fetch_wdata[31:16];
        in_cnt = 2'd0;
        if (push) in_cnt = drop_lo_q ? 2'd1 : 2'd2;
    end

    // Window built from storage, with zero forced past the stored level.
    always_comb begin
        st_lo  = 16'h0000;
        st_hi  = 16'h0000;
        st_vld = 2'd0;
        if (level_q >= W_LEVEL'(1)) begin
            st_lo  = buf_q[rd_ptr_q];
            st_vld = 2'd1;
        end
        if (level_q >= W_LEVEL'(2)) begin
            st_hi  = buf_q[ptr_add(rd_ptr_q, 2'd1)];
            st_vld = 2'd2;
        end
    end

    // Output window and the split between consumed-from-storage and consumed-from-bus.
    always_comb begin
        cir      = {st_hi, st_lo};
        cir_vld  = st_vld;
        skip_cnt = 2'd0;
        pop_cnt  = jump_now ? 2'd0 : cir_use;
`ifdef REVIVE_FETCH_BYPASS_EN
        if (push && (level_q == '0)) begin
            cir      = {((in_cnt == 2'd2) ? in_hw1 : 16'h0000), in_hw0};
            cir_vld  = in_cnt;
            skip_cnt = cir_use;
            pop_cnt  = 2'd0;
        end
`endif
        cir_instr_vld = (cir_vld >= ((cir[1:0] == 2'b11) ? 2'd2 : 2'd1));
    end

    // Storage write ports: up to two halfwords, skipping any consumed on bypass.
    always_comb begin
        wr_cnt = in_cnt - skip_cnt;
        we0    = (wr_cnt != 2'd0);
        we1    = (wr_cnt == 2'd2);
        idx0   = wr_ptr_q;
        idx1   = ptr_add(wr_ptr_q, 2'd1);
        wd0    = (skip_cnt == 2'd0) ? in_hw0 : in_hw1;
        wd1    = in_hw1;
    end

    // Next-state for level, pointers and drop flag; a jump overrides everything.
    always_comb begin
        level_d   = level_q + W_LEVEL'(wr_cnt) - W_LEVEL'(pop_cnt);
        rd_ptr_d  = ptr_add(rd_ptr_q, pop_cnt);
        wr_ptr_d  = ptr_add(wr_ptr_q, wr_cnt);
        drop_lo_d = push ? 1'b0 : drop_lo_q;
        if (jump_now) begin
            level_d   = '0;
            rd_ptr_d  = wr_ptr_q;
            wr_ptr_d  = wr_ptr_q;
            drop_lo_d = jump_target_hw;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q   <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            drop_lo_q <= 1'b0;
        end else begin
            level_q   <= level_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            drop_lo_q <= drop_lo_d;
        end
    end

    // Halfword storage; contents are masked by level so it needs no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH_HW; i++) begin
            if (we0 && (idx0 == PW'(i))) buf_q[i] <= wd0;
            if (we1 && (idx1 == PW'(i))) buf_q[i] <= wd1;
        end
    end

    // Decode may never consume more halfwords than the window holds.
    a_use_le_vld: assert property (@(posedge clk) disable iff (!rst_n)
        !jump_now |-> (cir_use <= cir_vld));

endmodule
